// File: rtl/ss_rvc_lsu.sv
// Load/store unit: single-beat data-memory requests over valid/ready,
// aligned and extended load return, alignment/range fault detection.
module ss_rvc_lsu #(
    parameter int unsigned XLEN             = 32,
    parameter int unsigned SIZE_I_MEM       = 32'h400,
    parameter int unsigned MSB_D_MEM        = 9,
    parameter int unsigned D_MEM_OFFSET     = SIZE_I_MEM,
    parameter int unsigned SIZE_D_MEM       = 2 ** (MSB_D_MEM + 1),
    parameter int unsigned MSB_ENC_REG_FILE = 4
) (
    input  logic                      QClk,
    input  logic                      RstQnnnH,
    input  logic                      ExValid,
    input  logic                      ExOp,
    input  logic [2:0]                ExFunct3,
    input  logic [XLEN-1:0]           ExAddr,
    input  logic [XLEN-1:0]           ExWrData,
    input  logic [MSB_ENC_REG_FILE:0] ExRd,
    output logic                      LsuBusy,
    output logic                      MemReqValid,
    input  logic                      MemReqReady,
    output logic                      MemReqOp,
    output logic [XLEN-1:0]           MemReqAddr,
    output logic [3:0]                MemReqByteEn,
    output logic [XLEN-1:0]           MemReqWrData,
    input  logic                      MemRspValid,
    input  logic [XLEN-1:0]           MemRspData,
    output logic                      WbValid,
    output logic [MSB_ENC_REG_FILE:0] WbRd,
    output logic [XLEN-1:0]           WbData,
    output logic                      LsuFault,
    output logic [XLEN-1:0]           LsuFaultAddr
);

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // One extra bit so the upper bound cannot wrap at the top of the address space.
    localparam logic [XLEN:0] DM_LO = (XLEN+1)'(D_MEM_OFFSET);
    localparam logic [XLEN:0] DM_HI = (XLEN+1)'(D_MEM_OFFSET) + (XLEN+1)'(SIZE_D_MEM);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;
    state_t state, state_nxt;

    logic                      funct3_ok, misaligned, out_of_range;
    logic                      start, fault, take_rsp;
    logic [1:0]                ex_size;
    logic [3:0]                ex_be;
    logic [XLEN-1:0]           ex_wdata;
    logic [1:0]                req_lane;
    logic [2:0]                req_funct3;
    logic [MSB_ENC_REG_FILE:0] req_rd;
    logic [XLEN-1:0]           rsp_shifted, rsp_ext;

    always_comb begin
        ex_size = ExFunct3[1:0];
        if (ExOp == OP_WR)
            funct3_ok = !ExFunct3[2] && (ExFunct3[1:0] != 2'b11);
        else
            funct3_ok = (ExFunct3[1:0] != 2'b11) && !(ExFunct3[2] && ExFunct3[1]);
        misaligned   = !funct3_ok
                     || ((ex_size == 2'b01) && ExAddr[0])
                     || ((ex_size == 2'b10) && (ExAddr[1:0] != 2'b00));
        out_of_range = ({1'b0, ExAddr} < DM_LO) || ({1'b0, ExAddr} >= DM_HI);

        unique case (ex_size)
            2'b00:   ex_be = 4'b0001 << ExAddr[1:0];
            2'b01:   ex_be = 4'b0011 << ExAddr[1:0];
            default: ex_be = 4'b1111;
        endcase
        unique case (ex_size)
            2'b00:   ex_wdata = {4{ExWrData[7:0]}};
            2'b01:   ex_wdata = {2{ExWrData[15:0]}};
            default: ex_wdata = ExWrData;
        endcase
    end

    always_comb begin
        rsp_shifted = MemRspData >> {req_lane, 3'b000};
        unique case (req_funct3)
            3'b000:  rsp_ext = {{(XLEN-8){rsp_shifted[7]}}, rsp_shifted[7:0]};
            3'b001:  rsp_ext = {{(XLEN-16){rsp_shifted[15]}}, rsp_shifted[15:0]};
            3'b100:  rsp_ext = {{(XLEN-8){1'b0}}, rsp_shifted[7:0]};
            3'b101:  rsp_ext = {{(XLEN-16){1'b0}}, rsp_shifted[15:0]};
            default: rsp_ext = rsp_shifted;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        start       = (state == IDLE) && ExValid && !(misaligned || out_of_range);
        fault       = (state == IDLE) && ExValid && (misaligned || out_of_range);
        take_rsp    = (state == WAIT_RSP) && MemRspValid;
        MemReqValid = (state == REQ);
        LsuBusy     = (state != IDLE) || start;
        unique case (state)
            IDLE:     if (start) state_nxt = REQ;
            REQ:      if (MemReqReady) state_nxt = (MemReqOp == OP_WR) ? IDLE : WAIT_RSP;
            WAIT_RSP: if (MemRspValid) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge QClk) begin
        if (RstQnnnH) begin
            state        <= IDLE;
            WbValid      <= 1'b0;
            LsuFault     <= 1'b0;
            LsuFaultAddr <= '0;
            MemReqOp     <= OP_RD;
            MemReqAddr   <= '0;
            MemReqByteEn <= '0;
            MemReqWrData <= '0;
            req_lane     <= '0;
            req_funct3   <= '0;
            req_rd       <= '0;
            WbRd         <= '0;
            WbData       <= '0;
        end else begin
            state    <= state_nxt;
            WbValid  <= take_rsp;
            LsuFault <= fault;
            if (fault)
                LsuFaultAddr <= ExAddr;
            // Request fields only load in IDLE, so they stay frozen while REQ waits for ready.
            if (start) begin
                MemReqOp     <= ExOp;
                MemReqAddr   <= {ExAddr[XLEN-1:2], 2'b00};
                MemReqByteEn <= ex_be;
                MemReqWrData <= ex_wdata;
                req_lane     <= ExAddr[1:0];
                req_funct3   <= ExFunct3;
                req_rd       <= ExRd;
            end
            if (take_rsp) begin
                WbRd   <= req_rd;
                WbData <= rsp_ext;
            end
        end
    end

endmodule

// File: tb/tb_ss_rvc_lsu.sv
// Scoreboard bench for ss_rvc_lsu: stimulus pushes expected requests, load results
// and faults from a byte-level reference model; a negedge monitor pops and compares.
module tb_ss_rvc_lsu;

    localparam int unsigned OFF = 'h400;
    localparam int unsigned SZ  = 'h400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_op = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_addr = '0;
    logic [31:0] ex_wr_data = '0;
    logic [4:0]  ex_rd = '0;
    logic        lsu_busy;
    logic        req_valid;
    logic        req_ready = 1'b0;
    logic        req_op;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        lsu_fault;
    logic [31:0] lsu_fault_addr;

    typedef struct { logic op; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } req_t;
    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

    req_t        req_q[$];
    wb_t         wb_q[$];
    logic [31:0] fault_q[$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    ss_rvc_lsu #(
        .XLEN(32), .SIZE_I_MEM(OFF), .MSB_D_MEM(9), .D_MEM_OFFSET(OFF),
        .SIZE_D_MEM(SZ), .MSB_ENC_REG_FILE(4)
    ) dut (
        .QClk(clk), .RstQnnnH(rst), .ExValid(ex_valid), .ExOp(ex_op), .ExFunct3(ex_funct3),
        .ExAddr(ex_addr), .ExWrData(ex_wr_data), .ExRd(ex_rd), .LsuBusy(lsu_busy),
        .MemReqValid(req_valid), .MemReqReady(req_ready), .MemReqOp(req_op),
        .MemReqAddr(req_addr), .MemReqByteEn(req_be), .MemReqWrData(req_wdata),
        .MemRspValid(rsp_valid), .MemRspData(rsp_data), .WbValid(wb_valid), .WbRd(wb_rd),
        .WbData(wb_data), .LsuFault(lsu_fault), .LsuFaultAddr(lsu_fault_addr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes, 0 for an undefined funct3.
    function automatic int unsigned acc_bytes(input logic op, input logic [2:0] f3);
        if (op) begin
            case (f3)
                3'd0: return 1;
                3'd1: return 2;
                3'd2: return 4;
                default: return 0;
            endcase
        end
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit is_legal(input logic op, input logic [2:0] f3, input logic [31:0] addr);
        int unsigned n = acc_bytes(op, f3);
        longint unsigned a = 64'(addr);
        if (n == 0) return 0;
        if ((addr % n) != 0) return 0;
        if (a < 64'(OFF) || a >= 64'(OFF) + 64'(SZ)) return 0;
        return 1;
    endfunction

    function automatic logic [3:0] model_be(input int unsigned n, input logic [31:0] addr);
        int unsigned m = ((1 << n) - 1) << (addr % 4);
        return m[3:0];
    endfunction

    function automatic logic [31:0] model_wdata(input int unsigned n, input logic [31:0] d);
        logic [31:0] r = '0;
        for (int unsigned i = 0; i < 4; i++)
            r = r | (((d >> (8 * (i % n))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [31:0] model_load(input int unsigned n, input logic [2:0] f3,
                                               input logic [31:0] addr, input logic [31:0] word);
        logic [31:0] v;
        logic [31:0] mask;
        if (n == 4) return word;
        v    = word >> (8 * (addr % 4));
        mask = (32'd1 << (8 * n)) - 1;
        v    = v & mask;
        if (!f3[2] && (((v >> (8 * n - 1)) & 1) != 0)) v = v | ~mask;
        return v;
    endfunction

    task automatic check_reset_state;
        check("rst_busy", lsu_busy, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_fault", lsu_fault, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_req_be", req_be, 0);
        check("rst_req_wdata", req_wdata, 0);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_fault_addr", lsu_fault_addr, 0);
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic issue(input logic op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] word,
                         input int stall, input int rsp_delay);
        int unsigned n = acc_bytes(op, f3);
        bit legal = is_legal(op, f3, addr);
        bit hs = 0;
        int k;
        req_t r;
        wb_t w;
        if (!legal) fault_q.push_back(addr);
        else begin
            r.op = op; r.addr = addr & ~32'h3; r.be = model_be(n, addr); r.wdata = model_wdata(n, wdata);
            req_q.push_back(r);
            if (!op) begin
                w.rd = rd; w.data = model_load(n, f3, addr, word);
                wb_q.push_back(w);
            end
        end
        ex_valid = 1; ex_op = op; ex_funct3 = f3; ex_addr = addr; ex_wr_data = wdata; ex_rd = rd;
        #1 check("busy_on_issue", lsu_busy, legal);
        tick;
        ex_valid = 0;
        if (!legal) return;
        for (k = 0; k < 100; k++) begin
            check("busy_in_req", lsu_busy, 1);
            req_ready = (stall < 0) ? 1'($urandom_range(0, 1)) : (k >= stall);
            hs = req_valid && req_ready;
            tick;
            if (hs) break;
        end
        if (!hs) check("req_handshake_timeout", hs, 1);
        req_ready = 0;
        if (op) return;
        for (int d = 0; d < rsp_delay; d++) begin
            check("busy_wait_rsp", lsu_busy, 1);
            tick;
        end
        rsp_valid = 1; rsp_data = word;
        check("busy_rsp_cycle", lsu_busy, 1);
        tick;
        rsp_valid = 0; rsp_data = $urandom;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a request, result or fault.
    initial begin
        req_t        er;
        wb_t         ew;
        logic [31:0] ef;
        logic [31:0] last_wb = '0;
        logic [31:0] last_fault = '0;
        bit          hold = 0;
        logic [68:0] held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last_wb = '0; last_fault = '0; hold = 0;
                continue;
            end
            check("spurious_req_valid", req_valid && (req_q.size() == 0), 0);
            if (hold && req_valid)
                check("req_fields_stable", {req_op, req_addr, req_be, req_wdata}, held);
            if (req_valid && req_ready && req_q.size() > 0) begin
                er = req_q.pop_front();
                check("req_op", req_op, er.op);
                check("req_addr", req_addr, er.addr);
                check("req_be", req_be, er.be);
                if (er.op) check("req_wdata", req_wdata, er.wdata);
            end
            hold = req_valid && !req_ready;
            held = {req_op, req_addr, req_be, req_wdata};
            if (wb_valid) begin
                if (wb_q.size() == 0) check("spurious_wb_valid", wb_valid, 0);
                else begin
                    ew = wb_q.pop_front();
                    check("wb_rd", wb_rd, ew.rd);
                    check("wb_data", wb_data, ew.data);
                    last_wb = ew.data;
                end
            end else check("wb_data_hold", wb_data, last_wb);
            if (lsu_fault) begin
                if (fault_q.size() == 0) check("spurious_fault", lsu_fault, 0);
                else begin
                    ef = fault_q.pop_front();
                    check("fault_addr", lsu_fault_addr, ef);
                    last_fault = ef;
                end
            end else check("fault_addr_hold", lsu_fault_addr, last_fault);
        end
    end

    initial begin
        logic        op;
        logic [2:0]  f3;
        logic [31:0] addr;
        int unsigned sel;
        req_t        r;

        repeat (3) tick;
        rst = 0;
        check_reset_state();
        tick;

        issue(1, 3'd2, OFF + 'h10, 32'hDEADBEEF, 5'd0, 32'h0, 0, 0);
        issue(0, 3'd0, OFF + 'h13, 32'h0, 5'd5, 32'h80FF1234, 0, 0);
        issue(0, 3'd4, OFF + 'h13, 32'h0, 5'd6, 32'h80FF1234, 0, 1);
        issue(1, 3'd1, OFF + 'h2, 32'h0000ABCD, 5'd0, 32'h0, 5, 0);
        issue(0, 3'd2, OFF + 'h6, 32'h0, 5'd7, 32'h0, 0, 0);
        issue(0, 3'd2, 32'h0, 32'h0, 5'd8, 32'h0, 0, 0);
        issue(0, 3'd0, OFF + SZ - 1, 32'h0, 5'd9, 32'h12345678, 0, 2);
        issue(0, 3'd0, OFF + SZ, 32'h0, 5'd9, 32'h0, 0, 0);
        issue(1, 3'd0, OFF - 1, 32'h55, 5'd0, 32'h0, 0, 0);
        issue(0, 3'd3, OFF + 'h10, 32'h0, 5'd1, 32'h0, 0, 0);
        issue(1, 3'd4, OFF + 'h10, 32'h0, 5'd0, 32'h0, 0, 0);
        issue(0, 3'd1, OFF + 'h11, 32'h0, 5'd2, 32'h0, 0, 0);
        issue(0, 3'd5, OFF + 'h12, 32'h0, 5'd3, 32'hF00D8001, 0, 0);
        issue(0, 3'd1, OFF + 'h12, 32'h0, 5'd4, 32'hF00D8001, 0, 3);
        issue(0, 3'd2, OFF + SZ - 4, 32'h0, 5'd31, 32'hCAFEF00D, 2, 0);

        // LHU interrupted by reset while waiting for its response.
        r.op = 0; r.addr = OFF + 'h10; r.be = 4'b1100; r.wdata = '0;
        req_q.push_back(r);
        ex_valid = 1; ex_op = 0; ex_funct3 = 3'd5; ex_addr = OFF + 'h12; ex_rd = 5'd12;
        tick;
        ex_valid = 0; req_ready = 1;
        tick;
        req_ready = 0;
        check("busy_before_reset", lsu_busy, 1);
        rst = 1;
        tick;
        rst = 0;
        check_reset_state();
        rsp_valid = 1; rsp_data = 32'hBEEF1234;
        tick;
        rsp_valid = 0;
        check("no_wb_after_reset", wb_valid, 0);
        tick;
        issue(1, 3'd0, OFF + 'h21, 32'h000000A5, 5'd0, 32'h0, 0, 0);

        for (int t = 0; t < 300; t++) begin
            op = 1'($urandom_range(0, 1));
            f3 = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                              : (op ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2) | (3'($urandom_range(0, 1)) << 2)));
            sel = $urandom_range(0, 9);
            if (sel == 0) addr = $urandom;
            else if (sel == 1) addr = $urandom_range(0, OFF - 1);
            else if (sel == 2) addr = $urandom_range(OFF + SZ - 16, OFF + SZ + 16);
            else addr = OFF + $urandom_range(0, SZ - 1);
            if (sel >= 6 && acc_bytes(op, f3) != 0) addr = addr & ~(acc_bytes(op, f3) - 1);
            issue(op, f3, addr, $urandom, 5'($urandom), $urandom,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : -1, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) begin
                check("idle_not_busy", lsu_busy, 0);
                tick;
            end
        end

        repeat (4) tick;
        check("req_q_drained", req_q.size(), 0);
        check("wb_q_drained", wb_q.size(), 0);
        check("fault_q_drained", fault_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ss_rvc_lsu.md
Name: ss_rvc_lsu

Overview:
- Load/store unit of the ss_rvc core. Sits directly downstream of the execute stage and consumes the ALU effective address, store data and funct3 produced for OP_LOAD / OP_STORE instructions.
- Issues single-beat requests to the data memory over a valid/ready handshake.
- Returns aligned, sign- or zero-extended load data to write-back.
- Stalls the pipeline while an access is outstanding.

Parameters:
- XLEN, 32, data/address width (from ss_rvc_pkg)
- D_MEM_OFFSET, SIZE_I_MEM, byte base address of data memory
- SIZE_D_MEM, 2**(MSB_D_MEM+1), data memory size in bytes
- MSB_ENC_REG_FILE, 4, MSB of the destination register index

Ports:
- QClk  in  1  core clock
- RstQnnnH  in  1  synchronous active-high reset
- ExValid  in  1  execute stage presents a memory instruction this cycle
- ExOp  in  1  t_req_op: RD=load, WR=store
- ExFunct3  in  3  000=B, 001=H, 010=W, 100=BU, 101=HU (loads); 000/001/010 (stores)
- ExAddr  in  XLEN  effective byte address
- ExWrData  in  XLEN  store source register value
- ExRd  in  MSB_ENC_REG_FILE+1  load destination register
- LsuBusy  out  1  stall request to fetch/decode/execute
- MemReqValid  out  1  request valid to data memory
- MemReqReady  in  1  memory accepts request
- MemReqOp  out  1  t_req_op
- MemReqAddr  out  XLEN  word-aligned address (bits[1:0]=0)
- MemReqByteEn  out  4  byte enables
- MemReqWrData  out  XLEN  store data, lane-shifted
- MemRspValid  in  1  read data valid (loads only)
- MemRspData  in  XLEN  read word
- WbValid  out  1  one-cycle load result strobe
- WbRd  out  MSB_ENC_REG_FILE+1  destination register
- WbData  out  XLEN  extended load data
- LsuFault  out  1  one-cycle strobe: misaligned or out-of-range access
- LsuFaultAddr  out  XLEN  offending address, held until next fault

Behaviour:
- FSM states: IDLE, REQ, WAIT_RSP.
- Reset: state=IDLE; LsuBusy, MemReqValid, WbValid and LsuFault = 0; all data/address outputs = 0.
- IDLE, ExValid=1: check alignment and range.
  - Misaligned: H with addr[0]=1, or W with addr[1:0]!=0.
  - Out of range: addr < D_MEM_OFFSET or addr >= D_MEM_OFFSET+SIZE_D_MEM.
  - Either case: next cycle LsuFault=1 and LsuFaultAddr=ExAddr. No memory request. Stay IDLE.
  - Otherwise: register the request. Next cycle is REQ with MemReqValid=1.
- LsuBusy = 1 whenever state != IDLE, and combinationally in IDLE while ExValid=1 with a legal access. Execute holds its inputs while LsuBusy=1.
- Byte enables: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111.
- Store data: B replicated to all 4 lanes; H replicated to both halves; W unchanged.
- REQ: request fields held stable until MemReqReady=1 (no dropping, no change while valid).
  - Handshake with WR: return to IDLE next cycle.
  - Handshake with RD: go to WAIT_RSP. MemReqValid drops the next cycle.
- WAIT_RSP: wait indefinitely for MemRspValid.
  - On MemRspValid=1: next cycle WbValid=1 with WbRd and WbData; return to IDLE.
  - Extraction selects the lane by the registered addr[1:0]. B/H sign-extend, BU/HU zero-extend, W passes through.
  - MemRspValid seen outside WAIT_RSP is ignored.
- Minimum latency:
  - Store: 2 cycles, ExValid to the handshake cycle, if ready is already high.
  - Load: response arrives the cycle after the handshake, and WbValid asserts 1 cycle after that.
- Back-to-back accesses: a new ExValid is sampled in the same cycle the FSM returns to IDLE. No bubble is required beyond the FSM.
- WbData holds its value after WbValid deasserts.
- Reset mid-access (any state): forced to IDLE, all strobes cleared, and any pending response is dropped.
- Illegal funct3 (011, 110, 111, or 1xx on a store): treated as misaligned and raises LsuFault.

Test Plan:
- Store word, addr=D_MEM_OFFSET+0x10, data=0xDEADBEEF, ready=1 -> one request with Op=WR, Addr=0x410, ByteEn=1111, WrData=0xDEADBEEF. No WbValid.
- Load byte at addr offset+0x13, MemRspData=0x80FF_1234 -> ByteEn=1000. LB gives WbData=0xFFFFFF80; LBU gives 0x00000080. WbRd matches ExRd.
- Store half at offset+0x2 with data=0x0000ABCD and ready held low 5 cycles -> request fields stable 5 cycles, ByteEn=1100, WrData=0xABCDABCD, LsuBusy high throughout.
- LW at offset+0x6 -> LsuFault=1 and LsuFaultAddr=0x406. MemReqValid never asserts.
- LW at address 0x0 (I-mem range) -> LsuFault=1, no memory request.
- LHU in WAIT_RSP, RstQnnnH pulsed before the response -> IDLE. A later MemRspValid produces no WbValid, and the next store proceeds normally.
